// File: rtl/cnn_pkg.sv
// Shared constants for the CNN streaming blocks: default widths and
// the encoding of the two ping-pong destinations.
package cnn_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int BURST_LEN_DEF = 28;   // one MNIST row

    localparam logic DEST_A = 1'b1;
    localparam logic DEST_B = 1'b0;

endpackage : cnn_pkg

// File: rtl/ping_pong_demux_out_slot.sv
// One-entry register slice with valid/ready handshake. The held word only
// changes on a load, so the data register is stable whenever the slot is
// empty or the consumer is stalling.
module out_slot #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              can_load_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // Slot accepts when empty or when its word leaves this same cycle.
    assign can_load_o  = ~valid_q | out_ready_i;
    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;

    // Next-state: a load wins over a drain so back-to-back words keep valid high.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers; reset discards any held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule : out_slot

// File: rtl/ping_pong_demux.sv
// Ping-pong demultiplexer: routes fixed-length bursts from one producer to
// consumer A or B, each output buffered by a one-entry slot (latency 1).
// Optional macro PINGPONG_AUTO_EN: destinations alternate A, B, A, ...
// starting with A after reset and sel is ignored; otherwise the destination
// is sel sampled on the first accepted word of each burst.
module ping_pong_demux
    import cnn_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sel,
    output logic [DATA_W-1:0] out_a_data,
    output logic              out_a_valid,
    input  logic              out_a_ready,
    output logic [DATA_W-1:0] out_b_data,
    output logic              out_b_valid,
    input  logic              out_b_ready,
    output logic              cur_dest,
    output logic              burst_done
);

    // A 1-word burst still needs a 1-bit counter that simply stays at zero.
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dest_q, dest_d;
    logic             done_q, done_d;

    logic burst_start;
    logic new_dest;
    logic dest_now;
    logic accept;
    logic last_word;
    logic a_can_load, b_can_load;
    logic load_a, load_b;

    assign burst_start = (cnt_q == '0);
    assign last_word   = (cnt_q == CNT_LAST);

`ifdef PINGPONG_AUTO_EN
    logic prev_dest_q;
    logic unused_sel;

    assign unused_sel = sel;
    // prev_dest_q resets to B so the first burst after reset lands on A.
    assign new_dest   = ~prev_dest_q;

    // Remember the destination of the most recently started burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_dest_q <= DEST_B;
        end else if (accept && burst_start) begin
            prev_dest_q <= new_dest;
        end
    end
`else
    assign new_dest = sel;
`endif

    // The first word of a burst already goes to the freshly chosen output.
    assign dest_now = burst_start ? new_dest : dest_q;

    assign in_ready = ~reset & ((dest_now == DEST_A) ? a_can_load : b_can_load);
    assign accept   = in_valid & in_ready;
    assign load_a   = accept & (dest_now == DEST_A);
    assign load_b   = accept & (dest_now == DEST_B);

    assign cur_dest   = dest_q;
    assign burst_done = done_q;

    // Next-state for burst position, latched destination and done pulse.
    always_comb begin
        cnt_d  = cnt_q;
        dest_d = dest_q;
        done_d = accept & last_word;
        if (accept) begin
            cnt_d = last_word ? '0 : cnt_q + CNT_W'(1);
            if (burst_start) begin
                dest_d = dest_now;
            end
        end
    end

    // Burst control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            dest_q <= DEST_A;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dest_q <= dest_d;
            done_q <= done_d;
        end
    end

    out_slot #(.DATA_W(DATA_W)) u_slot_a (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load_a),
        .load_data_i (in_data),
        .can_load_o  (a_can_load),
        .out_data_o  (out_a_data),
        .out_valid_o (out_a_valid),
        .out_ready_i (out_a_ready)
    );

    out_slot #(.DATA_W(DATA_W)) u_slot_b (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load_b),
        .load_data_i (in_data),
        .can_load_o  (b_can_load),
        .out_data_o  (out_b_data),
        .out_valid_o (out_b_valid),
        .out_ready_i (out_b_ready)
    );

endmodule : ping_pong_demux

// File: tb/tb_ping_pong_demux.sv
// Bench for ping_pong_demux: two instances (BURST_LEN=4 and BURST_LEN=1)
// share one stimulus stream; each is compared every cycle with a
// burst-level reference model.
module tb_ping_pong_demux;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        sel = 1'b0;
    logic        out_a_ready = 1'b0;
    logic        out_b_ready = 1'b0;

    logic        d_in_ready [2];
    logic        d_a_valid  [2];
    logic        d_b_valid  [2];
    logic [15:0] d_a_data   [2];
    logic [15:0] d_b_data   [2];
    logic        d_cur_dest [2];
    logic        d_done     [2];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ping_pong_demux #(.DATA_W(16), .BURST_LEN(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(d_in_ready[0]), .sel(sel),
        .out_a_data(d_a_data[0]), .out_a_valid(d_a_valid[0]), .out_a_ready(out_a_ready),
        .out_b_data(d_b_data[0]), .out_b_valid(d_b_valid[0]), .out_b_ready(out_b_ready),
        .cur_dest(d_cur_dest[0]), .burst_done(d_done[0])
    );

    ping_pong_demux #(.DATA_W(16), .BURST_LEN(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(d_in_ready[1]), .sel(sel),
        .out_a_data(d_a_data[1]), .out_a_valid(d_a_valid[1]), .out_a_ready(out_a_ready),
        .out_b_data(d_b_data[1]), .out_b_valid(d_b_valid[1]), .out_b_ready(out_b_ready),
        .cur_dest(d_cur_dest[1]), .burst_done(d_done[1])
    );

    // Reference model: words accepted since reset, bursts started, and a
    // capacity-one buffer per output (index 1 = A, 0 = B).
    int          bl [2] = '{4, 1};
    int          acc [2];
    int          bursts [2];
    logic        curd [2];
    logic        done_m [2];
    logic        full [2][2];
    logic [15:0] last [2][2];
    logic        exp_rdy [2];
    logic        exp_dest [2];
    bit          acc0_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic ready_of(input logic o);
        return o ? out_a_ready : out_b_ready;
    endfunction

    function automatic logic model_dest(input int i);
        if (acc[i] % bl[i] == 0) begin
`ifdef PINGPONG_AUTO_EN
            return (bursts[i] % 2 == 0) ? 1'b1 : 1'b0;
`else
            return sel;
`endif
        end
        return curd[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            acc[i] = 0; bursts[i] = 0; curd[i] = 1'b1; done_m[i] = 1'b0;
            for (int o = 0; o < 2; o++) begin
                full[i][o] = 1'b0; last[i][o] = '0;
            end
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit acc_now;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            exp_dest[i] = model_dest(i);
            exp_rdy[i]  = !reset && (!full[i][int'(exp_dest[i])] || ready_of(exp_dest[i]));
            chk($sformatf("in_ready%0d", i),  32'(d_in_ready[i]), 32'(exp_rdy[i]));
            chk($sformatf("a_valid%0d", i),   32'(d_a_valid[i]),  32'(full[i][1]));
            chk($sformatf("b_valid%0d", i),   32'(d_b_valid[i]),  32'(full[i][0]));
            chk($sformatf("a_data%0d", i),    32'(d_a_data[i]),   32'(last[i][1]));
            chk($sformatf("b_data%0d", i),    32'(d_b_data[i]),   32'(last[i][0]));
            chk($sformatf("cur_dest%0d", i),  32'(d_cur_dest[i]), 32'(curd[i]));
            chk($sformatf("burst_done%0d", i),32'(d_done[i]),     32'(done_m[i]));
        end
        @(posedge clk);
        acc0_last = 1'b0;
        if (reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                acc_now = in_valid && exp_rdy[i];
                for (int o = 0; o < 2; o++)
                    if (full[i][o] && ready_of(o[0])) full[i][o] = 1'b0;
                done_m[i] = 1'b0;
                if (acc_now) begin
                    full[i][int'(exp_dest[i])] = 1'b1;
                    last[i][int'(exp_dest[i])] = in_data;
                    if (acc[i] % bl[i] == 0) begin
                        curd[i] = exp_dest[i];
                        bursts[i]++;
                    end
                    acc[i]++;
                    done_m[i] = (acc[i] % bl[i] == 0);
                end
                if (i == 0) acc0_last = acc_now;
            end
        end
        #1;
    endtask

    // Send n words base, base+1, ... (counted on the BURST_LEN=4 instance).
    // With flip set, sel is inverted after the first word of the run.
    task automatic push_words(input int n, input logic [15:0] base, input logic s0, input bit flip);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 40 * n + 40) begin
            in_valid = 1'b1;
            in_data  = base + 16'(k);
            sel      = (flip && k > 0) ? ~s0 : s0;
            step();
            if (acc0_last) k++;
            guard++;
        end
        in_valid = 1'b0;
        if (k < n) chk("push_timeout", 32'(k), 32'(n));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int c = 0; c < n; c++) step();
    endtask

    initial begin
        int k;
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        step(); step();
        reset = 1'b0;
        idle(1);

        // Single A burst, both consumers ready.
        out_a_ready = 1'b1; out_b_ready = 1'b1;
        push_words(4, 16'h0001, 1'b1, 1'b0);
        idle(2);

        // sel flips mid-burst; then a burst with sel=1.
        push_words(4, 16'h0011, 1'b0, 1'b1);
        push_words(4, 16'h0021, 1'b1, 1'b0);
        idle(2);

        // Leave a word parked in B with its consumer stalled.
        push_words(4, 16'h0031, 1'b0, 1'b0);
        out_b_ready = 1'b0;
        idle(1);

        // A burst while A stalls for 5 cycles and B stays stalled.
        out_a_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 14 && k < 4; c++) begin
            out_a_ready = (c >= 5);
            in_valid = 1'b1; sel = 1'b1;
            in_data  = 16'h0100 + 16'(k);
            step();
            if (acc0_last) k++;
        end
        in_valid = 1'b0;
        chk("stall_burst_words", 32'(k), 32'd4);
        out_a_ready = 1'b1;
        idle(2);
        out_b_ready = 1'b1;
        idle(2);

        // Reset after two words of a burst, then a full fresh burst.
        push_words(2, 16'h0201, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        push_words(4, 16'h0301, 1'b0, 1'b0);
        idle(2);

        // Single-word bursts on the BURST_LEN=1 instance.
        push_words(1, 16'hAAAA, 1'b1, 1'b0);
        push_words(1, 16'hBBBB, 1'b0, 1'b0);
        push_words(1, 16'hCCCC, 1'b1, 1'b0);
        idle(3);

        // Randomised traffic with back-pressure and occasional reset.
        for (int c = 0; c < 400; c++) begin
            reset       = ($urandom_range(0, 63) == 0);
            in_valid    = $urandom_range(0, 3) != 0;
            in_data     = 16'($urandom);
            sel         = 1'($urandom);
            out_a_ready = $urandom_range(0, 3) != 0;
            out_b_ready = $urandom_range(0, 3) != 0;
            step();
        end
        reset = 1'b0;
        out_a_ready = 1'b1; out_b_ready = 1'b1;
        idle(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_ping_pong_demux

// File: doc/ping_pong_demux.md
PING_PONG_DEMUX -- requirements
Module: ping_pong_demux

Interface
REQ-001 Parameter DATA_W, default 16: width of every data port.
REQ-002 Parameter BURST_LEN, default 28: words per burst (one MNIST row); legal range 1..1023.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 in_data  in  DATA_W  producer word.
REQ-007 in_valid  in  1  producer word present.
REQ-008 in_ready  out  1  block accepts word this cycle.
REQ-009 sel  in  1  destination for next burst; 1 = A, 0 = B.
REQ-010 out_a_data / out_b_data  out  DATA_W  registered word to consumer A / B.
REQ-011 out_a_valid / out_b_valid  out  1  word held for A / B.
REQ-012 out_a_ready / out_b_ready  in  1  consumer A / B takes word.
REQ-013 cur_dest  out  1  destination of current burst; 1 = A, 0 = B.
REQ-014 burst_done  out  1  one-cycle pulse, last word of a burst accepted.

Function
REQ-015 Accept = in_valid & in_ready; transfer on an output = valid & ready on that output.
REQ-016 Each output owns a one-entry holding register; an accepted word appears on the selected output the next cycle (latency 1).
REQ-017 in_ready = selected slot empty, or selected slot transferring this cycle; combinational, no dependency on in_valid.
REQ-018 Simultaneous transfer-out and accept on the same slot: slot reloads, valid stays 1 (full throughput, 1 word/cycle).
REQ-019 A stalled non-selected output never blocks input.
REQ-020 Burst counter (ceil(log2(BURST_LEN)) bits) increments per accept; wraps from BURST_LEN-1 to 0, asserting burst_done the following cycle.
REQ-021 Destination latched at each burst start (counter==0 with accept); sel changes mid-burst have no effect.
REQ-022 BURST_LEN=1: every word is a burst; destination re-evaluated per word, burst_done per accept.
REQ-023 Output data registers are held unchanged while valid is low or ready is low.
REQ-024 Word order per output preserved; no word dropped or duplicated.

Reset
REQ-025 On reset: out_a_valid, out_b_valid, burst_done = 0; out_a_data, out_b_data = 0; counter = 0; cur_dest = 1.
REQ-026 Reset mid-burst discards held words; next accept starts a new burst.
REQ-027 in_ready is 0 while reset is high.

Configuration
REQ-028 Macro PINGPONG_AUTO_EN defined: destination at each burst start is the inverse of the previous burst's destination (first burst after reset = A); sel ignored.
REQ-029 Macro undefined: destination at each burst start = sel sampled that cycle; no auto-toggle logic synthesized.

Structure
REQ-030 Shared package cnn_pkg holds DATA_W default, BURST_LEN default, DEST_A=1 / DEST_B=0 constants.
REQ-031 Sub-module out_slot (one-entry register slice with valid/ready) instantiated twice; counter and destination logic in top.

Verification
REQ-032 Reset, then BURST_LEN=4, sel=1, 4 words 0x0001..0x0004 back-to-back, both readies 1 -> A receives 1..4 at cycles 1..4 after accept, burst_done pulses once, B valid never 1.
REQ-033 Macro undefined, sel=0 for burst 1, sel toggled to 1 mid-burst -> all 4 words on B; next burst on A.
REQ-034 PINGPONG_AUTO_EN, 12 words, BURST_LEN=4 -> bursts routed A, B, A; sel toggling ignored; 3 burst_done pulses.
REQ-035 out_a_ready=0 for 5 cycles during an A burst -> in_ready=0 after slot fills, out_a_data stable; B stalled during A burst does not affect in_ready.
REQ-036 Reset asserted after 2 words of a 4-word burst -> valids 0, data 0, cur_dest=1; next 4 words form a complete new burst.
REQ-037 BURST_LEN=1, auto mode, 0xAAAA,0xBBBB,0xCCCC -> A,B,A with burst_done every accept.
